// File: rtl/typer_pkg.sv
// typer_pkg: shared scancodes, FSM encoding and key kinds
// Used by ghost_typer and ghost_keymap
package typer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_MAKE,
    S_HOLD,
    S_BREAK,
    S_NEXT
  } fsm_t;

  typedef enum logic [1:0] {
    K_LETTER,
    K_SPACE,
    K_TYPO,
    K_BACK
  } kind_t;

  localparam logic [1:0] GS_SELECT = 2'd0;
  localparam logic [1:0] GS_COUNT  = 2'd1;
  localparam logic [1:0] GS_INGAME = 2'd2;
  localparam logic [1:0] GS_FINISH = 2'd3;

  localparam logic [6:0] SC_SPACE = 7'd41;
  localparam logic [6:0] SC_BACK  = 7'd102;

  // entry n is the scancode of letter code n; entry 0 unused
  localparam logic [26:0][6:0] SC_TAB = {
    7'd26, 7'd53, 7'd34, 7'd29, 7'd42,
    7'd60, 7'd44, 7'd27, 7'd45, 7'd21,
    7'd77, 7'd68, 7'd49, 7'd58, 7'd75,
    7'd66, 7'd59, 7'd67, 7'd51, 7'd52,
    7'd43, 7'd36, 7'd35, 7'd33, 7'd50,
    7'd28, 7'd0
  };

  // wrong neighbour letter for a deliberate typo
  function automatic logic [4:0] typo_code(
    input logic [4:0] n
  );
    return (n >= 5'd26) ? 5'd1 : n + 5'd1;
  endfunction

endpackage

// File: rtl/ghost_keymap.sv
// ghost_keymap: letter code to scancode lookup
// Codes outside 1..26 map to scancode 0
module ghost_keymap
  import typer_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] scancode
);

  // table lookup, guarded against unused codes
  always_comb begin
    scancode = 7'd0;
    if (code >= 5'd1 && code <= 5'd26)
      scancode = SC_TAB[code];
  end

endmodule

// File: rtl/ghost_typer.sv
// ghost_typer: scripted keyboard typist driven by game state
// Optional typo + backspace injection: define GHOST_TYPO_EN
module ghost_typer
  import typer_pkg::*;
#(
  parameter int MAX_LETTERS = 15,
  parameter int HOLD_TICKS  = 1
) (
  input  logic         clk_div,
  input  logic         rst,
  input  logic [1:0]   state,
  input  logic [74:0]  word,
  input  logic [4:0]   wordnum,
  input  logic [6:0]   interval,
  input  logic [6:0]   target,
  output logic [127:0] key_down,
  output logic [8:0]   last_change,
  output logic         key_valid,
  output logic         word_req,
  output logic [6:0]   words_done,
  output logic         done
);

  localparam logic [4:0]  MAXL  = 5'(MAX_LETTERS);
  localparam logic [15:0] HOLDN = 16'(HOLD_TICKS);

  fsm_t        fsm, fsm_n;
  logic [15:0] cnt, cnt_n;
  logic [4:0]  idx, idx_n;
  kind_t       kind_c, kind_q;
  logic [6:0]  key_c, key_q;
  logic [8:0]  last_q;
  logic [79:0] word_ext;
  logic [6:0]  bitpos;
  logic [4:0]  letter, code_sel;
  logic [6:0]  km_sc;
  logic [6:0]  iv, wd_inc;
  logic        is_letter, ingame;

  assign ingame   = (state == GS_INGAME);
  assign word_ext = {5'd0, word};
  assign bitpos   = 7'(idx[3:0]) * 7'd5;
  assign letter   = word_ext[bitpos +: 5];
  assign iv       = (interval == 7'd0) ? 7'd1 : interval;
  assign wd_inc   = (words_done == 7'd127) ?
                    7'd127 : words_done + 7'd1;
  assign done     = (words_done == target);

  assign is_letter = (idx < wordnum) &&
                     (idx < MAXL) &&
                     (letter != 5'd0);

`ifdef GHOST_TYPO_EN
  logic [2:0] lcnt;
  logic [1:0] ph;

  // typo phase: 0 normal, 1 typo typed, 2 erased
  always_comb begin
    kind_c = is_letter ? K_LETTER : K_SPACE;
    if (is_letter && ph == 2'd1)
      kind_c = K_BACK;
    else if (is_letter && ph == 2'd0 &&
             lcnt == 3'd7)
      kind_c = K_TYPO;
  end

  assign code_sel = (kind_c == K_TYPO) ?
                    typo_code(letter) : letter;

  // running letter count and typo phase
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      lcnt <= 3'd0;
      ph   <= 2'd0;
    end else if (fsm == S_NEXT && ingame) begin
      unique case (kind_q)
        K_LETTER: begin
          lcnt <= lcnt + 3'd1;
          ph   <= 2'd0;
        end
        K_TYPO:  ph <= 2'd1;
        K_BACK:  ph <= 2'd2;
        K_SPACE: ph <= 2'd0;
      endcase
    end
  end
`else
  // plain letters followed by a space
  always_comb begin
    kind_c = is_letter ? K_LETTER : K_SPACE;
  end

  assign code_sel = letter;
`endif

  ghost_keymap u_keymap (
    .code     (code_sel),
    .scancode (km_sc)
  );

  // pick the scancode for the current keystroke
  always_comb begin
    unique case (1'b1)
      kind_c == K_SPACE: key_c = SC_SPACE;
      kind_c == K_BACK:  key_c = SC_BACK;
      default:           key_c = km_sc;
    endcase
  end

  // state register with counters and index
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      fsm <= S_IDLE;
      cnt <= 16'd0;
      idx <= 5'd0;
    end else begin
      fsm <= fsm_n;
      cnt <= cnt_n;
      idx <= idx_n;
    end
  end

  // next state; NEXT doubles as first wait tick
  always_comb begin
    fsm_n = fsm;
    cnt_n = cnt;
    idx_n = idx;
    if (!ingame) begin
      fsm_n = S_IDLE;
      cnt_n = 16'd0;
      idx_n = 5'd0;
    end else begin
      unique case (fsm)
        S_IDLE: begin
          if (!done) begin
            fsm_n = S_WAIT;
            cnt_n = 16'd0;
            idx_n = 5'd0;
          end
        end
        S_WAIT: begin
          if (cnt + 16'd1 >= {9'd0, iv}) begin
            fsm_n = S_MAKE;
            cnt_n = 16'd0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        S_MAKE: begin
          fsm_n = (HOLD_TICKS == 0) ?
                  S_BREAK : S_HOLD;
          cnt_n = 16'd0;
        end
        S_HOLD: begin
          if (cnt + 16'd1 >= HOLDN) begin
            fsm_n = S_BREAK;
            cnt_n = 16'd0;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
        S_BREAK: fsm_n = S_NEXT;
        S_NEXT: begin
          cnt_n = 16'd1;
          fsm_n = (iv == 7'd1) ? S_MAKE : S_WAIT;
          if (kind_q == K_LETTER)
            idx_n = idx + 5'd1;
          if (kind_q == K_SPACE) begin
            idx_n = 5'd0;
            if (wd_inc == target) begin
              fsm_n = S_IDLE;
              cnt_n = 16'd0;
            end
          end
        end
        default: begin
          fsm_n = S_IDLE;
          cnt_n = 16'd0;
          idx_n = 5'd0;
        end
      endcase
    end
  end

  // latch the key chosen while in MAKE
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      key_q  <= 7'd0;
      kind_q <= K_LETTER;
      last_q <= 9'd0;
    end else if (fsm == S_MAKE) begin
      key_q  <= key_c;
      kind_q <= kind_c;
      last_q <= {2'b00, key_c};
    end
  end

  // completed words: cleared in SELECT
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst)
      words_done <= 7'd0;
    else if (state == GS_SELECT)
      words_done <= 7'd0;
    else if (ingame && fsm == S_NEXT &&
             kind_q == K_SPACE)
      words_done <= wd_inc;
  end

  // keyboard outputs decoded from FSM state
  always_comb begin
    key_down    = '0;
    key_valid   = 1'b0;
    word_req    = 1'b0;
    last_change = last_q;
    unique case (fsm)
      S_MAKE: begin
        key_down[key_c] = 1'b1;
        key_valid       = 1'b1;
        last_change     = {2'b00, key_c};
      end
      S_HOLD:  key_down[key_q] = 1'b1;
      S_BREAK: key_valid = 1'b1;
      S_NEXT:  word_req = ingame &&
                          (kind_q == K_SPACE);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ghost_typer.sv
// tb_ghost_typer: randomized scoreboard bench
// Expected keystrokes come from a word-level model
module tb_ghost_typer;

  localparam int HOLD = 1;

  logic         clk_div = 1'b0;
  logic         rst;
  logic [1:0]   state;
  logic [74:0]  word;
  logic [4:0]   wordnum;
  logic [6:0]   interval, target;
  logic [127:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid, word_req;
  logic [6:0]   words_done;
  logic         done;

  ghost_typer #(
    .MAX_LETTERS (15),
    .HOLD_TICKS  (HOLD)
  ) dut (
    .clk_div     (clk_div),
    .rst         (rst),
    .state       (state),
    .word        (word),
    .wordnum     (wordnum),
    .interval    (interval),
    .target      (target),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .word_req    (word_req),
    .words_done  (words_done),
    .done        (done)
  );

  always #5 clk_div = ~clk_div;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int exp_gap  = 0;
  int gen      = 0;
  int wr_cnt   = 0;
  int cyc      = 0;
  int mdl_lcnt = 0;
  int prev_make = -1;
  int seen_gen  = -1;
  int mon_e, mon_sc;
  logic mon_mk;

  int sc_tab[27] = '{0, 28, 50, 33, 35, 36, 43,
                     52, 51, 67, 59, 66, 75, 58,
                     49, 68, 77, 21, 45, 27, 44,
                     60, 42, 29, 34, 53, 26};

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // word-level model: letters until a stop, then SPACE
  task automatic model_push(input logic [74:0] w,
                            input logic [4:0] wn,
                            input logic [6:0] tg,
                            input int limit);
    int tmp[$];
    int n, li;
    for (int k = 0; k < int'(tg); k++) begin
      n = 0;
      while (n < int'(wn) && n < 15) begin
        li = int'(w[n*5 +: 5]);
        if (li == 0) break;
`ifdef GHOST_TYPO_EN
        if (mdl_lcnt % 8 == 7) begin
          tmp.push_back(1000 + sc_tab[li % 26 + 1]);
          tmp.push_back(sc_tab[li % 26 + 1]);
          tmp.push_back(1000 + 102);
          tmp.push_back(102);
        end
        mdl_lcnt++;
`endif
        tmp.push_back(1000 + sc_tab[li]);
        tmp.push_back(sc_tab[li]);
        n++;
      end
      tmp.push_back(1000 + 41);
      tmp.push_back(41);
    end
    for (int i = 0; i < tmp.size() && i < limit; i++)
      exp_q.push_back(tmp[i]);
  endtask

  // monitor: pop and compare on every key event
  always @(negedge clk_div) begin
    cyc++;
    if (word_req) wr_cnt++;
    if (!rst && key_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got %0d expected none",
                 last_change);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_mk = (mon_e >= 1000);
        mon_sc = mon_e % 1000;
        check("event_is_make", 128'(key_down != '0),
              128'(mon_mk));
        check("last_change", 128'(last_change),
              128'(mon_sc));
        if (mon_mk) begin
          check("key_down_onehot", key_down,
                128'(1) << mon_sc);
          if (gen == seen_gen && prev_make >= 0)
            check("make_gap", 128'(cyc - prev_make),
                  128'(exp_gap));
          prev_make = cyc;
          seen_gen  = gen;
        end
      end
    end
  end

  task automatic setup(input logic [74:0] w,
                       input logic [4:0] wn,
                       input logic [6:0] iv,
                       input logic [6:0] tg,
                       input int limit);
    state = 2'd0;
    @(negedge clk_div);
    @(negedge clk_div);
    word     = w;
    wordnum  = wn;
    interval = iv;
    target   = tg;
    model_push(w, wn, tg, limit);
    exp_gap = ((iv == 0) ? 1 : int'(iv)) + 2 + HOLD;
    gen++;
    state = 2'd2;
  endtask

  task automatic wait_hold(input int sc, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_div);
      if (key_down[sc] && !key_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL hold_timeout: got none expected hold of %0d", sc);
    end
  endtask

  task automatic run_word(input logic [74:0] w,
                          input logic [4:0] wn,
                          input logic [6:0] iv,
                          input logic [6:0] tg);
    int wr0;
    bit ok = 0;
    setup(w, wn, iv, tg, 100000);
    wr0 = wr_cnt;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_div);
      if (done && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: got %0d pending expected 0",
               exp_q.size());
      exp_q.delete();
    end
    check("words_done", 128'(words_done), 128'(tg));
    check("word_req_count", 128'(wr_cnt - wr0), 128'(tg));
    check("done", 128'(done), 128'(1));
    repeat (12) @(negedge clk_div);
    check("idle_after_done", 128'(exp_q.size()), 128'(0));
    check("words_done_held", 128'(words_done), 128'(tg));
  endtask

  logic [74:0] cat, term, w;
  logic [4:0]  wn;
  int          zp;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cat  = {60'd0, 5'd20, 5'd1, 5'd3};
    term = {50'd0, 5'd5, 5'd4, 5'd3, 5'd0, 5'd1};
    rst = 1'b1;
    state = 2'd0;
    word = '0;
    wordnum = 5'd0;
    interval = 7'd1;
    target = 7'd1;
    repeat (3) @(negedge clk_div);
    check("rst_key_down", key_down, 128'(0));
    check("rst_key_valid", 128'(key_valid), 128'(0));
    check("rst_word_req", 128'(word_req), 128'(0));
    check("rst_words_done", 128'(words_done), 128'(0));
    check("rst_last_change", 128'(last_change), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    rst = 1'b0;
    @(negedge clk_div);

    setup(cat, 5'd3, 7'd2, 7'd1, 3);
    wait_hold(28, 200);
    #2 rst = 1'b1;
    #1;
    check("rst_hold_key_down", key_down, 128'(0));
    check("rst_hold_key_valid", 128'(key_valid), 128'(0));
    check("rst_hold_last", 128'(last_change), 128'(0));
    state = 2'd0;
    @(negedge clk_div);
    @(negedge clk_div);
    rst = 1'b0;
    mdl_lcnt = 0;
    check("rst_hold_queue", 128'(exp_q.size()), 128'(0));

    setup(cat, 5'd3, 7'd2, 7'd2, 11);
    for (int i = 0; i < 200 && words_done != 7'd1; i++)
      @(negedge clk_div);
    wait_hold(28, 200);
    state = 2'd3;
    @(negedge clk_div);
    check("drop_key_down", key_down, 128'(0));
    check("drop_key_valid", 128'(key_valid), 128'(0));
    check("drop_words_done", 128'(words_done), 128'(1));
    repeat (10) @(negedge clk_div);
    check("drop_queue", 128'(exp_q.size()), 128'(0));
    check("finish_hold", 128'(words_done), 128'(1));
    state = 2'd0;
    @(negedge clk_div);
    check("select_clear", 128'(words_done), 128'(0));
    mdl_lcnt = 4;

    run_word(cat, 5'd3, 7'd2, 7'd1);
    run_word(cat, 5'd3, 7'd0, 7'd1);
    run_word(cat, 5'd3, 7'd1, 7'd1);
    run_word(term, 5'd5, 7'd2, 7'd1);
    run_word({65'd0, 5'd9, 5'd14}, 5'd2, 7'd1, 7'd3);
    run_word(cat, 5'd3, 7'd1, 7'd0);
    run_word({35'd0, 5'd8, 5'd7, 5'd6, 5'd5,
              5'd4, 5'd3, 5'd2, 5'd1},
             5'd8, 7'd1, 7'd1);

    for (int r = 0; r < 8; r++) begin
      w = '0;
      for (int i = 0; i < 15; i++)
        w[i*5 +: 5] = 5'($urandom_range(1, 26));
      if ($urandom_range(0, 3) == 0) begin
        zp = int'($urandom_range(0, 14));
        w[zp*5 +: 5] = 5'd0;
      end
      wn = 5'($urandom_range(0, 20));
      run_word(w, wn, 7'($urandom_range(0, 4)),
               7'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
